// File: rtl/sdram_pkg.sv
`default_nettype none
// ============================================================================
// Module   : sdram_pkg
// Brief    : Command encodings, mode-register fields and bank state for the
//            SDR SDRAM device responder.
// Revision : 1.0
// ============================================================================
package sdram_pkg;

    // {nRAS, nCAS, nWE}
    localparam logic [2:0] CMD_LOAD_MODE  = 3'b000;
    localparam logic [2:0] CMD_REFRESH    = 3'b001;
    localparam logic [2:0] CMD_PRECHARGE  = 3'b010;
    localparam logic [2:0] CMD_ACTIVE     = 3'b011;
    localparam logic [2:0] CMD_WRITE      = 3'b100;
    localparam logic [2:0] CMD_READ       = 3'b101;
    localparam logic [2:0] CMD_BURST_TERM = 3'b110;
    localparam logic [2:0] CMD_NOP        = 3'b111;

    localparam int MR_BL_LSB    = 0;
    localparam int MR_CL_LSB    = 4;
    localparam int MR_WB_BIT    = 9;
    localparam int A_AP_BIT     = 10;
    localparam int ROW_W        = 13;
    localparam int COL_W        = 9;

    typedef enum logic [3:0] {
        ERR_NONE       = 4'd0,
        ERR_ACT_OPEN   = 4'd1,
        ERR_BANK_IDLE  = 4'd2,
        ERR_TRCD       = 4'd3,
        ERR_RFS_OPEN   = 4'd4,
        ERR_TRC        = 4'd5,
        ERR_MODE_OPEN  = 4'd6,
        ERR_MODE_BAD   = 4'd7,
        ERR_NO_MODE    = 4'd8
    } err_code_e;

    typedef struct packed {
        logic             open;
        logic [ROW_W-1:0] row;
        logic [7:0]       trcd_cnt;
    } bank_state_t;

    function automatic logic mode_supported(input logic [2:0] cl, input logic [2:0] bl);
        return ((cl == 3'd2) || (cl == 3'd3)) && (bl == 3'd0);
    endfunction

endpackage
`default_nettype wire

// File: rtl/sdram_responder_ram.sv
`default_nettype none
// ============================================================================
// Module   : sdram_responder_ram
// Brief    : Single-port 2^AW x 16 block RAM, byte enables, registered read.
// Revision : 1.0
// ============================================================================
module sdram_responder_ram #(
    parameter int AW = 14
) (
    input  logic          clk,
    input  logic          i_en,
    input  logic          i_we,
    input  logic [1:0]    i_be,
    input  logic [AW-1:0] i_addr,
    input  logic [15:0]   i_wdata,
    output logic [15:0]   o_rdata
);

    logic [15:0] r_mem [2**AW];
    logic [15:0] r_rdata;

    always_ff @(posedge clk) begin
        if (i_en && i_we) begin
            if (i_be[0]) r_mem[i_addr][7:0]  <= i_wdata[7:0];
            if (i_be[1]) r_mem[i_addr][15:8] <= i_wdata[15:8];
        end
        if (i_en && !i_we) begin
            r_rdata <= r_mem[i_addr];
        end
    end

    assign o_rdata = r_rdata;

endmodule
`default_nettype wire

// File: rtl/sdram_responder.sv
`default_nettype none
// ============================================================================
// Module   : sdram_responder
// Brief    : SDR SDRAM device model: decodes pin commands, serves them from
//            block RAM and flags protocol violations.
// Revision : 1.0
// ============================================================================
module sdram_responder
    import sdram_pkg::*;
#(
    parameter int MEM_AW = 14,
    parameter int TRCD   = 2,
    parameter int TRC    = 6
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        sd_ncs,
    input  logic        sd_nras,
    input  logic        sd_ncas,
    input  logic        sd_nwe,
    input  logic [1:0]  sd_ba,
    input  logic [12:0] sd_a,
    input  logic        sd_dqml,
    input  logic        sd_dqmh,
    input  logic [15:0] sd_dq_i,
    output logic [15:0] sd_dq_o,
    output logic        sd_dq_oe,
    output logic        mode_ok,
    output logic [15:0] rfs_count,
    output logic        err,
    output logic [3:0]  err_code
);

    localparam int c_addr_w = 2 + ROW_W + COL_W;

    logic [2:0]          w_cmd;
    bank_state_t         w_bank;
    logic                w_any_open;
    logic                w_is_read;
    logic                w_is_write;
    logic                w_access;
    err_code_e           w_err;
    logic [2:0]          w_mr_cl;
    logic [2:0]          w_mr_bl;
    logic                w_mode_good;
    logic [c_addr_w-1:0] w_addr_full;
    logic [MEM_AW-1:0]   w_ram_addr;
    logic [15:0]         w_ram_rdata;

    bank_state_t r_bank [4];
    logic [2:0]  r_cas_lat;
    logic        r_mode_ok;
    logic [15:0] r_rfs_count;
    logic [7:0]  r_trc_cnt;
    logic        r_err;
    err_code_e   r_err_code;
    logic        r_s1_vld;
    logic        r_s1_cl3;
    logic [1:0]  r_s1_mask;
    logic        r_s2_vld;
    logic        r_s2_cl3;
    logic [15:0] r_s2_data;
    logic        r_s3_vld;
    logic [15:0] r_s3_data;
    logic        r_dq_oe;
    logic [15:0] r_dq_o;

    assign w_cmd       = sd_ncs ? CMD_NOP : {sd_nras, sd_ncas, sd_nwe};
    assign w_bank      = r_bank[sd_ba];
    assign w_is_read   = (w_cmd == CMD_READ);
    assign w_is_write  = (w_cmd == CMD_WRITE);
    assign w_access    = (w_is_read || w_is_write) && w_bank.open;
    assign w_mr_cl     = sd_a[MR_CL_LSB +: 3];
    assign w_mr_bl     = sd_a[MR_BL_LSB +: 3];
    assign w_mode_good = mode_supported(w_mr_cl, w_mr_bl);
    assign w_addr_full = {sd_ba, w_bank.row, sd_a[COL_W-1:0]};
    assign w_ram_addr  = MEM_AW'(w_addr_full);

    always_comb begin
        w_any_open = 1'b0;
        for (int b = 0; b < 4; b++) begin
            w_any_open = w_any_open | r_bank[b].open;
        end
    end

    // One code per command; the more specific violation wins over "no mode".
    always_comb begin
        w_err = ERR_NONE;
        case (w_cmd)
            CMD_ACTIVE: begin
                if (w_bank.open)           w_err = ERR_ACT_OPEN;
                else if (r_trc_cnt != 8'd0) w_err = ERR_TRC;
                else if (!r_mode_ok)       w_err = ERR_NO_MODE;
            end
            CMD_READ, CMD_WRITE: begin
                if (!w_bank.open)                  w_err = ERR_BANK_IDLE;
                else if (w_bank.trcd_cnt != 8'd0)  w_err = ERR_TRCD;
                else if (!r_mode_ok)               w_err = ERR_NO_MODE;
            end
            CMD_REFRESH: begin
                if (w_any_open)             w_err = ERR_RFS_OPEN;
                else if (r_trc_cnt != 8'd0) w_err = ERR_TRC;
            end
            CMD_LOAD_MODE: begin
                if (w_any_open)        w_err = ERR_MODE_OPEN;
                else if (!w_mode_good) w_err = ERR_MODE_BAD;
            end
            default: w_err = ERR_NONE;
        endcase
    end

    sdram_responder_ram #(
        .AW (MEM_AW)
    ) u_ram (
        .clk     (clk),
        .i_en    (w_access),
        .i_we    (w_is_write),
        .i_be    ({~sd_dqmh, ~sd_dqml}),
        .i_addr  (w_ram_addr),
        .i_wdata (sd_dq_i),
        .o_rdata (w_ram_rdata)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int b = 0; b < 4; b++) begin
                r_bank[b] <= '0;
            end
            r_cas_lat   <= 3'd2;
            r_mode_ok   <= 1'b0;
            r_rfs_count <= 16'd0;
            r_trc_cnt   <= 8'd0;
            r_err       <= 1'b0;
            r_err_code  <= ERR_NONE;
            r_s1_vld    <= 1'b0;
            r_s1_cl3    <= 1'b0;
            r_s1_mask   <= 2'b00;
            r_s2_vld    <= 1'b0;
            r_s2_cl3    <= 1'b0;
            r_s2_data   <= 16'd0;
            r_s3_vld    <= 1'b0;
            r_s3_data   <= 16'd0;
            r_dq_oe     <= 1'b0;
            r_dq_o      <= 16'd0;
        end else begin
            for (int b = 0; b < 4; b++) begin
                if (r_bank[b].trcd_cnt != 8'd0) begin
                    r_bank[b].trcd_cnt <= r_bank[b].trcd_cnt - 8'd1;
                end
            end
            if (r_trc_cnt != 8'd0) begin
                r_trc_cnt <= r_trc_cnt - 8'd1;
            end

            case (w_cmd)
                CMD_ACTIVE: begin
                    if (!w_bank.open) begin
                        r_bank[sd_ba].open     <= 1'b1;
                        r_bank[sd_ba].row      <= sd_a;
                        r_bank[sd_ba].trcd_cnt <= 8'(TRCD - 1);
                    end
                end
                CMD_READ, CMD_WRITE: begin
                    if (w_bank.open && sd_a[A_AP_BIT]) begin
                        r_bank[sd_ba].open <= 1'b0;
                    end
                end
                CMD_PRECHARGE: begin
                    if (sd_a[A_AP_BIT]) begin
                        for (int b = 0; b < 4; b++) begin
                            r_bank[b].open <= 1'b0;
                        end
                    end else begin
                        r_bank[sd_ba].open <= 1'b0;
                    end
                end
                CMD_REFRESH: begin
                    r_rfs_count <= r_rfs_count + 16'd1;
                    r_trc_cnt   <= 8'(TRC - 1);
                end
                CMD_LOAD_MODE: begin
                    if (!w_any_open) begin
                        if (w_mode_good) begin
                            r_mode_ok <= 1'b1;
                            r_cas_lat <= w_mr_cl;
                        end else begin
                            r_mode_ok <= 1'b0;
                        end
                    end
                end
                default: ;
            endcase

            if ((w_err != ERR_NONE) && !r_err) begin
                r_err      <= 1'b1;
                r_err_code <= w_err;
            end

            // CAS latency is frozen per read at issue so later mode loads cannot retime it.
            r_s1_vld  <= w_access && w_is_read;
            r_s1_cl3  <= (r_cas_lat == 3'd3);
            r_s1_mask <= {sd_dqmh, sd_dqml};
            r_s2_vld  <= r_s1_vld;
            r_s2_cl3  <= r_s1_cl3;
            r_s2_data <= {r_s1_mask[1] ? 8'h00 : w_ram_rdata[15:8],
                          r_s1_mask[0] ? 8'h00 : w_ram_rdata[7:0]};
            r_s3_vld  <= r_s2_vld && r_s2_cl3;
            r_s3_data <= r_s2_data;

            if (r_s2_vld && !r_s2_cl3) begin
                r_dq_oe <= 1'b1;
                r_dq_o  <= r_s2_data;
            end else if (r_s3_vld) begin
                r_dq_oe <= 1'b1;
                r_dq_o  <= r_s3_data;
            end else begin
                r_dq_oe <= 1'b0;
                r_dq_o  <= 16'd0;
            end
        end
    end

    assign sd_dq_o   = r_dq_o;
    assign sd_dq_oe  = r_dq_oe;
    assign mode_ok   = r_mode_ok;
    assign rfs_count = r_rfs_count;
    assign err       = r_err;
    assign err_code  = r_err_code;

endmodule
`default_nettype wire

// File: tb/tb_sdram_responder.sv
`default_nettype none
// ============================================================================
// Module   : tb_sdram_responder
// Brief    : Self-checking bench for sdram_responder with a read-data scoreboard.
// Revision : 1.0
// ============================================================================
module tb_sdram_responder;

    localparam int c_mem_aw = 14;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        sd_ncs = 1'b1;
    logic        sd_nras = 1'b1;
    logic        sd_ncas = 1'b1;
    logic        sd_nwe = 1'b1;
    logic [1:0]  sd_ba = 2'd0;
    logic [12:0] sd_a = 13'd0;
    logic        sd_dqml = 1'b0;
    logic        sd_dqmh = 1'b0;
    logic [15:0] sd_dq_i = 16'd0;
    logic [15:0] sd_dq_o;
    logic        sd_dq_oe;
    logic        mode_ok;
    logic [15:0] rfs_count;
    logic        err;
    logic [3:0]  err_code;

    int          n_checks = 0;
    int          n_errors = 0;
    int          cyc = 0;
    int          cl = 2;
    logic [15:0] exp_q [$];
    int          due_q [$];
    logic [15:0] model [int];
    logic [15:0] mon_exp;
    int          mon_due;

    sdram_responder #(.MEM_AW(c_mem_aw), .TRCD(2), .TRC(6)) dut (
        .clk       (clk),
        .reset     (reset),
        .sd_ncs    (sd_ncs),
        .sd_nras   (sd_nras),
        .sd_ncas   (sd_ncas),
        .sd_nwe    (sd_nwe),
        .sd_ba     (sd_ba),
        .sd_a      (sd_a),
        .sd_dqml   (sd_dqml),
        .sd_dqmh   (sd_dqmh),
        .sd_dq_i   (sd_dq_i),
        .sd_dq_o   (sd_dq_o),
        .sd_dq_oe  (sd_dq_oe),
        .mode_ok   (mode_ok),
        .rfs_count (rfs_count),
        .err       (err),
        .err_code  (err_code)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard: every valid read cycle must match the oldest expectation, on time.
    always @(negedge clk) begin
        if (sd_dq_oe !== 1'b0) begin
            n_checks++;
            if (exp_q.size() == 0) begin
                n_errors++;
                $display("FAIL rd_unexpected: sd_dq_oe=%b sd_dq_o=%h at cycle %0d, required no read data", sd_dq_oe, sd_dq_o, cyc);
            end else begin
                mon_exp = exp_q.pop_front();
                mon_due = due_q.pop_front();
                if (sd_dq_o !== mon_exp || cyc != mon_due) begin
                    n_errors++;
                    $display("FAIL rd_data: got %h at cycle %0d, required %h at cycle %0d", sd_dq_o, cyc, mon_exp, mon_due);
                end
            end
        end
    end

    function automatic int maddr(input logic [1:0] ba, input logic [12:0] row, input logic [8:0] col);
        logic [23:0] f;
        f = {ba, row, col};
        return int'(f[c_mem_aw-1:0]);
    endfunction

    task automatic drive(input logic [2:0] op, input logic [1:0] ba, input logic [12:0] a,
                         input logic dqmh, input logic dqml, input logic [15:0] dq);
        sd_ncs = 1'b0;
        {sd_nras, sd_ncas, sd_nwe} = op;
        sd_ba = ba; sd_a = a; sd_dqmh = dqmh; sd_dqml = dqml; sd_dq_i = dq;
        @(negedge clk);
        sd_ncs = 1'b1;
        {sd_nras, sd_ncas, sd_nwe} = 3'b111;
        sd_dqmh = 1'b0; sd_dqml = 1'b0;
    endtask

    task automatic nop(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wr(input logic [1:0] ba, input logic [12:0] row, input logic [8:0] col,
                      input logic [15:0] dq, input logic dqmh, input logic dqml);
        logic [15:0] old;
        int ad;
        ad  = maddr(ba, row, col);
        old = model.exists(ad) ? model[ad] : 16'h0000;
        model[ad] = {dqmh ? old[15:8] : dq[15:8], dqml ? old[7:0] : dq[7:0]};
        drive(3'b100, ba, {4'b0000, col}, dqmh, dqml, dq);
    endtask

    task automatic rd(input logic [1:0] ba, input logic [12:0] row, input logic [8:0] col,
                      input logic ap, input logic dqmh, input logic dqml, input logic expect_data);
        logic [15:0] v;
        int ad;
        ad = maddr(ba, row, col);
        v  = model.exists(ad) ? model[ad] : 16'h0000;
        if (expect_data) begin
            exp_q.push_back({dqmh ? 8'h00 : v[15:8], dqml ? 8'h00 : v[7:0]});
            due_q.push_back(cyc + 1 + cl);
        end
        drive(3'b101, ba, {2'b00, ap, 1'b0, col}, dqmh, dqml, 16'h0000);
    endtask

    task automatic apply_reset();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        cl = 2;
    endtask

    task automatic drained(input string name);
        nop(8);
        n_checks++;
        if (exp_q.size() != 0) begin
            n_errors++;
            $display("FAIL %s_missing: %0d reads still pending, required 0", name, exp_q.size());
            exp_q.delete();
            due_q.delete();
        end
    endtask

    task automatic do_init();
        drive(3'b010, 2'd0, 13'h0400, 1'b0, 1'b0, 16'h0);
        drive(3'b001, 2'd0, 13'h0000, 1'b0, 1'b0, 16'h0);
        nop(7);
        drive(3'b001, 2'd0, 13'h0000, 1'b0, 1'b0, 16'h0);
        nop(7);
        drive(3'b000, 2'd0, 13'h0220, 1'b0, 1'b0, 16'h0);
        cl = 2;
        nop(1);
    endtask

    task automatic check_err(input string name, input logic e, input logic [3:0] code);
        n_checks++;
        if (err !== e || err_code !== code) begin
            n_errors++;
            $display("FAIL %s: err=%b err_code=%0d, required err=%b err_code=%0d", name, err, err_code, e, code);
        end
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        n_checks++;
        if ({sd_dq_oe, mode_ok, err} !== 3'b000 || sd_dq_o !== 16'h0 ||
            rfs_count !== 16'h0 || err_code !== 4'h0) begin
            n_errors++;
            $display("FAIL reset_state: oe=%b mode_ok=%b err=%b dq_o=%h rfs=%h code=%0d, required all zero",
                     sd_dq_oe, mode_ok, err, sd_dq_o, rfs_count, err_code);
        end
        reset = 1'b0;
    endtask

    task automatic test_init();
        do_init();
        n_checks++;
        if (mode_ok !== 1'b1) begin
            n_errors++;
            $display("FAIL init_mode_ok: got %b, required 1", mode_ok);
        end
        n_checks++;
        if (rfs_count !== 16'd2) begin
            n_errors++;
            $display("FAIL init_rfs_count: got %0d, required 2", rfs_count);
        end
        check_err("init_err", 1'b0, 4'd0);
    endtask

    task automatic test_write_read();
        drive(3'b011, 2'd1, 13'h0123, 1'b0, 1'b0, 16'h0);
        nop(1);
        wr(2'd1, 13'h0123, 9'h005, 16'hBEEF, 1'b0, 1'b0);
        rd(2'd1, 13'h0123, 9'h005, 1'b0, 1'b0, 1'b0, 1'b1);
        wr(2'd1, 13'h0123, 9'h006, 16'h1234, 1'b0, 1'b0);
        rd(2'd1, 13'h0123, 9'h006, 1'b0, 1'b0, 1'b0, 1'b1);
        rd(2'd1, 13'h0123, 9'h005, 1'b0, 1'b0, 1'b0, 1'b1);
        drained("write_read");
        check_err("write_read_err", 1'b0, 4'd0);
    endtask

    task automatic test_byte_mask();
        wr(2'd1, 13'h0123, 9'h005, 16'h1122, 1'b1, 1'b0);
        rd(2'd1, 13'h0123, 9'h005, 1'b0, 1'b0, 1'b0, 1'b1);
        rd(2'd1, 13'h0123, 9'h005, 1'b0, 1'b0, 1'b1, 1'b1);
        wr(2'd1, 13'h0123, 9'h006, 16'hFFFF, 1'b1, 1'b1);
        rd(2'd1, 13'h0123, 9'h006, 1'b0, 1'b0, 1'b0, 1'b1);
        drained("byte_mask");
        check_err("byte_mask_err", 1'b0, 4'd0);
    endtask

    task automatic test_cas3();
        drive(3'b010, 2'd0, 13'h0400, 1'b0, 1'b0, 16'h0);
        drive(3'b000, 2'd0, 13'h0230, 1'b0, 1'b0, 16'h0);
        cl = 3;
        drive(3'b011, 2'd1, 13'h0123, 1'b0, 1'b0, 16'h0);
        nop(1);
        rd(2'd1, 13'h0123, 9'h005, 1'b0, 1'b0, 1'b0, 1'b1);
        rd(2'd1, 13'h0123, 9'h006, 1'b0, 1'b0, 1'b0, 1'b1);
        drained("cas3");
        check_err("cas3_err", 1'b0, 4'd0);
        drive(3'b010, 2'd0, 13'h0400, 1'b0, 1'b0, 16'h0);
        drive(3'b000, 2'd0, 13'h0241, 1'b0, 1'b0, 16'h0);
        n_checks++;
        if (mode_ok !== 1'b0) begin
            n_errors++;
            $display("FAIL bad_mode_ok: got %b, required 0", mode_ok);
        end
        check_err("bad_mode_err", 1'b1, 4'd7);
        drive(3'b011, 2'd1, 13'h0123, 1'b0, 1'b0, 16'h0);
        nop(1);
        rd(2'd1, 13'h0123, 9'h005, 1'b0, 1'b0, 1'b0, 1'b1);
        drained("cas3_kept");
        check_err("bad_mode_sticky", 1'b1, 4'd7);
    endtask

    task automatic test_closed_bank();
        apply_reset();
        do_init();
        rd(2'd2, 13'h0000, 9'h005, 1'b0, 1'b0, 1'b0, 1'b0);
        drained("closed_bank");
        check_err("closed_bank_err", 1'b1, 4'd2);
    endtask

    task automatic test_trcd();
        apply_reset();
        do_init();
        drive(3'b011, 2'd1, 13'h0123, 1'b0, 1'b0, 16'h0);
        rd(2'd1, 13'h0123, 9'h005, 1'b0, 1'b0, 1'b0, 1'b1);
        drained("trcd");
        check_err("trcd_err", 1'b1, 4'd3);
    endtask

    task automatic test_auto_precharge();
        apply_reset();
        do_init();
        drive(3'b011, 2'd1, 13'h0123, 1'b0, 1'b0, 16'h0);
        nop(1);
        rd(2'd1, 13'h0123, 9'h006, 1'b1, 1'b0, 1'b0, 1'b1);
        check_err("auto_pre_first_ok", 1'b0, 4'd0);
        rd(2'd1, 13'h0123, 9'h006, 1'b0, 1'b0, 1'b0, 1'b0);
        drained("auto_pre");
        check_err("auto_pre_err", 1'b1, 4'd2);
    endtask

    task automatic test_refresh_open();
        apply_reset();
        do_init();
        drive(3'b011, 2'd0, 13'h0010, 1'b0, 1'b0, 16'h0);
        nop(2);
        drive(3'b001, 2'd0, 13'h0000, 1'b0, 1'b0, 16'h0);
        check_err("refresh_open_err", 1'b1, 4'd4);
        n_checks++;
        if (rfs_count !== 16'd3) begin
            n_errors++;
            $display("FAIL refresh_open_count: got %0d, required 3", rfs_count);
        end
    endtask

    task automatic test_reset_mid_read();
        apply_reset();
        do_init();
        drive(3'b011, 2'd1, 13'h0123, 1'b0, 1'b0, 16'h0);
        nop(1);
        rd(2'd1, 13'h0123, 9'h005, 1'b0, 1'b0, 1'b0, 1'b0);
        apply_reset();
        drained("reset_mid_read");
        n_checks++;
        if ({sd_dq_oe, mode_ok, err} !== 3'b000 || sd_dq_o !== 16'h0 ||
            rfs_count !== 16'h0 || err_code !== 4'h0) begin
            n_errors++;
            $display("FAIL reset_mid_read_state: oe=%b mode_ok=%b err=%b dq_o=%h rfs=%h code=%0d, required all zero",
                     sd_dq_oe, mode_ok, err, sd_dq_o, rfs_count, err_code);
        end
    endtask

    initial begin
        test_reset();
        test_init();
        test_write_read();
        test_byte_mask();
        test_cas3();
        test_closed_bank();
        test_trcd();
        test_auto_precharge();
        test_refresh_open();
        test_reset_mid_read();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
